// File: rtl/pipe_types_pkg.sv
// Shared pipeline types for the hazard controller: controller mode and
// per-latch hold/bubble controls.
package pipe_types_pkg;
   typedef enum logic [1:0] {RUN, MEMWAIT, MULDIV} hazard_state_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } latch_ctrl_t;

   localparam latch_ctrl_t LATCH_GO    = '{stall: 1'b0, flush: 1'b0};
   localparam latch_ctrl_t LATCH_HOLD  = '{stall: 1'b1, flush: 1'b0};
   localparam latch_ctrl_t LATCH_FLUSH = '{stall: 1'b0, flush: 1'b1};

   function automatic int md_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction
endpackage

// File: rtl/hazard_raw_detect.sv
// Combinational RAW detector: flags when the ID instruction must wait for an
// EX/MEM producer that the forwarding network cannot satisfy.
module hazard_raw_detect #(
   parameter int REG_W  = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_use_rs,
   input  logic             i_id_use_rt,
   input  logic             i_ex_regwrite,
   input  logic             i_ex_memread,
   input  logic [REG_W-1:0] i_ex_wsel,
   input  logic             i_mem_regwrite,
   input  logic [REG_W-1:0] i_mem_wsel,
   output logic             o_raw_stall
);
   logic w_hit_ex;
   logic w_hit_mem;
   logic w_fwd;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   assign w_hit_ex = i_ex_regwrite && (i_ex_wsel != '0) &&
                     ((i_id_use_rs && (i_id_rs == i_ex_wsel)) ||
                      (i_id_use_rt && (i_id_rt == i_ex_wsel)));
   assign w_hit_mem = i_mem_regwrite && (i_mem_wsel != '0) &&
                      ((i_id_use_rs && (i_id_rs == i_mem_wsel)) ||
                       (i_id_use_rt && (i_id_rt == i_mem_wsel)));
   assign w_fwd = FWD_EN;

   assign o_raw_stall = w_fwd ? (w_hit_ex && i_ex_memread) : (w_hit_ex || w_hit_mem);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, mul/div interlock, redirect
// (held across freezes), RAW and fetch-miss stalls, plus stall/flush counters.
module hazard_ctrl
   import pipe_types_pkg::*;
#(
   parameter int REG_W      = 5,
   parameter bit FWD_EN     = 1'b1,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_wsel,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] mem_wsel,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             dhit,
   input  logic             ihit,
   input  logic             ex_redirect,
   input  logic             ex_muldiv_start,
   output logic             pc_en,
   output logic             stall_if_id,
   output logic             stall_id_ex,
   output logic             stall_ex_mem,
   output logic             stall_mem_wb,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             muldiv_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int               MD_W    = md_width(MULDIV_LAT);
   localparam logic [MD_W-1:0]  MD_LOAD = MD_W'(MULDIV_LAT - 1);

   logic [MD_W-1:0]  r_md_cnt;
   logic             r_redirect_pend;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic            w_mem_wait;
   logic            w_raw_stall;
   logic            w_redir;
   logic            w_redir_apply;
   hazard_state_t   w_state;
   logic            w_pc_en;
   logic            w_stall_mem_wb;
   latch_ctrl_t     w_if_id;
   latch_ctrl_t     w_id_ex;
   latch_ctrl_t     w_ex_mem;

   hazard_raw_detect #(
      .REG_W  (REG_W),
      .FWD_EN (FWD_EN)
   ) u_raw (
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_id_use_rs    (id_use_rs),
      .i_id_use_rt    (id_use_rt),
      .i_ex_regwrite  (ex_regwrite),
      .i_ex_memread   (ex_memread),
      .i_ex_wsel      (ex_wsel),
      .i_mem_regwrite (mem_regwrite),
      .i_mem_wsel     (mem_wsel),
      .o_raw_stall    (w_raw_stall)
   );

   assign w_mem_wait    = (mem_dren || mem_dwen) && !dhit;
   assign w_state       = w_mem_wait ? MEMWAIT : ((r_md_cnt != '0) ? MULDIV : RUN);
   assign w_redir       = ex_redirect || r_redirect_pend;
   assign w_redir_apply = !RST && (w_state == RUN) && w_redir;

   always_comb begin
      w_pc_en        = 1'b1;
      w_stall_mem_wb = 1'b0;
      w_if_id        = LATCH_GO;
      w_id_ex        = LATCH_GO;
      w_ex_mem       = LATCH_GO;
      if (RST) begin
         w_pc_en        = 1'b0;
         w_stall_mem_wb = 1'b1;
         w_if_id        = LATCH_HOLD;
         w_id_ex        = LATCH_HOLD;
         w_ex_mem       = LATCH_HOLD;
      end else begin
         case (w_state)
            MEMWAIT: begin
               w_pc_en        = 1'b0;
               w_stall_mem_wb = 1'b1;
               w_if_id        = LATCH_HOLD;
               w_id_ex        = LATCH_HOLD;
               w_ex_mem       = LATCH_HOLD;
            end
            MULDIV: begin
               // Mul/div keeps EX; MEM receives bubbles until it finishes.
               w_pc_en  = 1'b0;
               w_if_id  = LATCH_HOLD;
               w_id_ex  = LATCH_HOLD;
               w_ex_mem = LATCH_FLUSH;
            end
            default: begin
               if (w_redir) begin
                  w_if_id = LATCH_FLUSH;
                  w_id_ex = LATCH_FLUSH;
               end else if (w_raw_stall) begin
                  w_pc_en = 1'b0;
                  w_if_id = LATCH_HOLD;
                  w_id_ex = LATCH_FLUSH;
               end else if (!ihit) begin
                  w_pc_en = 1'b0;
                  w_if_id = LATCH_FLUSH;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_md_cnt        <= '0;
         r_redirect_pend <= 1'b0;
         r_stall_cnt     <= '0;
         r_flush_cnt     <= '0;
      end else begin
         if (!w_mem_wait) begin
            if (r_md_cnt != '0) begin
               r_md_cnt <= r_md_cnt - MD_W'(1);
            end else if (ex_muldiv_start) begin
               r_md_cnt <= MD_LOAD;
            end
         end
         // A redirect seen while frozen is latched so it survives its source dropping.
         if (w_mem_wait && ex_redirect) begin
            r_redirect_pend <= 1'b1;
         end else if (w_redir_apply) begin
            r_redirect_pend <= 1'b0;
         end
         if (!w_pc_en) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_redir_apply) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign pc_en        = w_pc_en;
   assign stall_if_id  = w_if_id.stall;
   assign stall_id_ex  = w_id_ex.stall;
   assign stall_ex_mem = w_ex_mem.stall;
   assign stall_mem_wb = w_stall_mem_wb;
   assign flush_if_id  = w_if_id.flush;
   assign flush_id_ex  = w_id_ex.flush;
   assign flush_ex_mem = w_ex_mem.flush;
   assign muldiv_busy  = !RST && (r_md_cnt != '0);
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: a forwarding and a non-forwarding
// instance share stimulus; expected control vectors are queued per cycle.
module tb_hazard_ctrl;
   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       use_rs;
      logic       use_rt;
      logic       ex_rw;
      logic       ex_mr;
      logic [4:0] ex_w;
      logic       mem_rw;
      logic [4:0] mem_w;
      logic       dren;
      logic       dwen;
      logic       dhit;
      logic       ihit;
      logic       redir;
      logic       mds;
   } stim_t;

   typedef struct packed {
      logic [8:0]  ctl;
      logic [8:0]  ctl_nf;
      logic [31:0] scnt;
      logic [31:0] fcnt;
   } exp_t;

   // {pc_en, stall if/id, id/ex, ex/mem, mem/wb, flush if/id, id/ex, ex/mem, muldiv_busy}
   localparam logic [8:0] C_RUN   = 9'b1_0000_000_0;
   localparam logic [8:0] C_FRZ   = 9'b0_1111_000_0;
   localparam logic [8:0] C_RAW   = 9'b0_1000_010_0;
   localparam logic [8:0] C_REDIR = 9'b1_0000_110_0;
   localparam logic [8:0] C_MD    = 9'b0_1100_001_1;
   localparam logic [8:0] C_IMISS = 9'b0_0000_100_0;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] id_rs, id_rt, ex_wsel, mem_wsel;
   logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread, mem_regwrite;
   logic       mem_dren, mem_dwen, dhit, ihit, ex_redirect, ex_muldiv_start;

   logic        pc_en, s_if_id, s_id_ex, s_ex_mem, s_mem_wb, f_if_id, f_id_ex, f_ex_mem, busy;
   logic [31:0] stall_cnt, flush_cnt;
   logic        n_pc_en, n_s_if_id, n_s_id_ex, n_s_ex_mem, n_s_mem_wb, n_f_if_id, n_f_id_ex, n_f_ex_mem, n_busy;
   logic [31:0] n_stall_cnt, n_flush_cnt;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   logic [31:0] es = 0;
   logic [31:0] ef = 0;

   always #5 CLK = ~CLK;

   hazard_ctrl u_dut (
      .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_wsel(ex_wsel), .mem_regwrite(mem_regwrite), .mem_wsel(mem_wsel),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen), .dhit(dhit), .ihit(ihit),
      .ex_redirect(ex_redirect), .ex_muldiv_start(ex_muldiv_start),
      .pc_en(pc_en), .stall_if_id(s_if_id), .stall_id_ex(s_id_ex),
      .stall_ex_mem(s_ex_mem), .stall_mem_wb(s_mem_wb), .flush_if_id(f_if_id),
      .flush_id_ex(f_id_ex), .flush_ex_mem(f_ex_mem), .muldiv_busy(busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.FWD_EN(1'b0)) u_dut_nf (
      .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_wsel(ex_wsel), .mem_regwrite(mem_regwrite), .mem_wsel(mem_wsel),
      .mem_dren(mem_dren), .mem_dwen(mem_dwen), .dhit(dhit), .ihit(ihit),
      .ex_redirect(ex_redirect), .ex_muldiv_start(ex_muldiv_start),
      .pc_en(n_pc_en), .stall_if_id(n_s_if_id), .stall_id_ex(n_s_id_ex),
      .stall_ex_mem(n_s_ex_mem), .stall_mem_wb(n_s_mem_wb), .flush_if_id(n_f_if_id),
      .flush_id_ex(n_f_id_ex), .flush_ex_mem(n_f_ex_mem), .muldiv_busy(n_busy),
      .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s      = '0;
      s.dhit = 1'b1;
      s.ihit = 1'b1;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      RST = s.rst; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
      ex_regwrite = s.ex_rw; ex_memread = s.ex_mr; ex_wsel = s.ex_w;
      mem_regwrite = s.mem_rw; mem_wsel = s.mem_w; mem_dren = s.dren; mem_dwen = s.dwen;
      dhit = s.dhit; ihit = s.ihit; ex_redirect = s.redir; ex_muldiv_start = s.mds;
   endtask

   // One clock cycle: drive, queue expectation, compare at negedge, advance past posedge.
   task automatic cyc(input string tag, input stim_t s, input logic [8:0] e, input logic [8:0] e_nf);
      exp_t x;
      exp_t got;
      apply(s);
      x.ctl = e; x.ctl_nf = e_nf; x.scnt = es; x.fcnt = ef;
      exp_q.push_back(x);
      @(negedge CLK);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         got = exp_q.pop_front();
         chk({tag, "_ctl"}, {23'd0, pc_en, s_if_id, s_id_ex, s_ex_mem, s_mem_wb,
                             f_if_id, f_id_ex, f_ex_mem, busy}, {23'd0, got.ctl});
         chk({tag, "_ctl_nf"}, {23'd0, n_pc_en, n_s_if_id, n_s_id_ex, n_s_ex_mem, n_s_mem_wb,
                                n_f_if_id, n_f_id_ex, n_f_ex_mem, n_busy}, {23'd0, got.ctl_nf});
         chk({tag, "_scnt"}, stall_cnt, got.scnt);
         chk({tag, "_fcnt"}, flush_cnt, got.fcnt);
         $display("cycle %-10s ctl=%b nf=%b scnt=%0d fcnt=%0d", tag,
                  {pc_en, s_if_id, s_id_ex, s_ex_mem, s_mem_wb, f_if_id, f_id_ex, f_ex_mem, busy},
                  {n_pc_en, n_s_if_id, n_s_id_ex, n_s_ex_mem, n_s_mem_wb, n_f_if_id, n_f_id_ex,
                   n_f_ex_mem, n_busy}, stall_cnt, flush_cnt);
      end
      if (s.rst) begin
         es = 0;
         ef = 0;
      end else begin
         if (!e[8]) es = es + 1;
         if (e[8] && e[3]) ef = ef + 1;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      apply(s);
      @(posedge CLK);
      #1;
      cyc("reset", s, C_FRZ, C_FRZ);
      cyc("reset2", s, C_FRZ, C_FRZ);

      s = idle();
      cyc("idle", s, C_RUN, C_RUN);

      // load-use on r5
      s = idle(); s.ex_rw = 1; s.ex_mr = 1; s.ex_w = 5; s.rs = 5; s.use_rs = 1;
      cyc("loaduse", s, C_RAW, C_RAW);
      s = idle();
      cyc("lu_clear", s, C_RUN, C_RUN);

      // register 0 never stalls
      s = idle(); s.ex_rw = 1; s.ex_mr = 1; s.ex_w = 0; s.rs = 0; s.use_rs = 1;
      cyc("r0", s, C_RUN, C_RUN);

      // MEM producer on r7: only the non-forwarding unit stalls
      s = idle(); s.mem_rw = 1; s.mem_w = 7; s.rt = 7; s.use_rt = 1;
      cyc("memhit", s, C_RUN, C_RAW);
      // EX ALU producer: forwarded unless forwarding is absent
      s = idle(); s.ex_rw = 1; s.ex_w = 3; s.rs = 3; s.use_rs = 1;
      cyc("exalu", s, C_RUN, C_RAW);
      // source not actually read
      s = idle(); s.ex_rw = 1; s.ex_mr = 1; s.ex_w = 9; s.rs = 9; s.use_rs = 0;
      cyc("nouse", s, C_RUN, C_RUN);

      // store waiting 3 cycles with a one-cycle redirect pulse
      s = idle(); s.dwen = 1; s.dhit = 0; s.redir = 1;
      cyc("mw1", s, C_FRZ, C_FRZ);
      s.redir = 0;
      cyc("mw2", s, C_FRZ, C_FRZ);
      cyc("mw3", s, C_FRZ, C_FRZ);
      s = idle();
      cyc("mw_redir", s, C_REDIR, C_REDIR);
      cyc("mw_after", s, C_RUN, C_RUN);

      // mul/div occupancy
      s = idle(); s.mds = 1;
      cyc("md_start", s, C_RUN, C_RUN);
      s = idle();
      for (int i = 0; i < 3; i++) cyc("md_busy", s, C_MD, C_MD);
      cyc("md_done", s, C_RUN, C_RUN);

      // redirect beats load-use and fetch miss
      s = idle(); s.redir = 1; s.ihit = 0; s.ex_rw = 1; s.ex_mr = 1; s.ex_w = 5; s.rs = 5; s.use_rs = 1;
      cyc("redir_pri", s, C_REDIR, C_REDIR);
      s = idle(); s.ihit = 0;
      cyc("imiss", s, C_IMISS, C_IMISS);
      s = idle(); s.ihit = 0; s.ex_rw = 1; s.ex_mr = 1; s.ex_w = 5; s.rt = 5; s.use_rt = 1;
      cyc("raw_imiss", s, C_RAW, C_RAW);

      // reset during the second mul/div cycle
      s = idle(); s.mds = 1;
      cyc("md2_start", s, C_RUN, C_RUN);
      s = idle();
      cyc("md2_busy", s, C_MD, C_MD);
      s.rst = 1;
      cyc("md2_rst", s, C_FRZ, C_FRZ);
      s = idle();
      cyc("post_rst", s, C_RUN, C_RUN);
      cyc("post_rst2", s, C_RUN, C_RUN);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
